uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL use parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 The block SHALL use parameter OVERSAMPLE, default 16, samples per bit, even and in the range 8..16.
REQ-003 The block SHALL use parameter SYNC_STAGES, default 2, the number of RxD synchroniser flops.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port baud_sel, input, 3 bits: baud select 0..7 = 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600.
REQ-007 The block SHALL have port data_bits, input, 2 bits: 0..3 = 5, 6, 7, 8 data bits.
REQ-008 The block SHALL have port parity_mode, input, 2 bits: 0 = none, 1 = even, 2 = odd, 3 = none.
REQ-009 The block SHALL have port stop2, input, 1 bit: 1 = check two stop bits, 0 = check one.
REQ-010 The block SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-011 The block SHALL have port rx_data, output, 8 bits: received byte, LSB first, unused upper bits 0.
REQ-012 The block SHALL have port rx_valid, output, 1 bit: rx_data and the error flags are valid.
REQ-013 The block SHALL have port rx_ready, input, 1 bit: consumer accepts the byte when rx_valid and rx_ready are both high.
REQ-014 The block SHALL have ports parity_err, frame_err, break_det, output, 1 bit each: per-byte status, qualified by rx_valid.
REQ-015 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-016 The tick generator SHALL pulse once every DIV clocks, with DIV = floor(CLK_FREQ / (baud*OVERSAMPLE)) from a constant table (115200 at default parameters gives DIV 54).
REQ-017 The tick counter SHALL restart on any baud_sel change and whenever the FSM is in IDLE.
REQ-018 rxd SHALL pass through SYNC_STAGES flops; the FSM uses only the synchronised value.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE -> START SHALL occur on a synchronised falling edge (previous value 1, current value 0).
REQ-021 Each bit value SHALL be the 2-of-3 majority of samples at tick indices OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-022 In START, a start-bit vote of 1 SHALL be a false start: return to IDLE with no output and no error.
REQ-023 DATA SHALL shift in data_bits+5 bits LSB first, then go to PARITY if parity_mode is 1 or 2, else to STOP.
REQ-024 parity_err SHALL be set when the XOR of the data bits and the parity bit is 1 (even mode) or 0 (odd mode); it SHALL be 0 when parity is none.
REQ-025 STOP SHALL check 1 or 2 stop bits; frame_err SHALL be set if any stop vote is 0.
REQ-026 break_det SHALL be set when all data bits, the parity bit and the first stop bit are 0; frame_err SHALL also be set in that case.
REQ-027 After a break, IDLE SHALL require at least one synchronised 1 before it accepts a new start edge.
REQ-028 Completion SHALL occur at the mid-sample tick of the last stop bit; the output register SHALL load in the following cycle and rx_valid SHALL rise.
REQ-029 The block SHALL return to IDLE immediately on completion, so back-to-back frames with 0 idle time are received.
REQ-030 If the output register still holds an unaccepted byte at completion, the new frame SHALL be discarded, the old byte retained, and overrun pulsed for 1 cycle.
REQ-031 If completion and acceptance (rx_valid and rx_ready) occur in the same cycle, the new byte SHALL load and overrun SHALL stay 0.
REQ-032 rx_valid SHALL stay high, with data and flags stable, until accepted.
REQ-033 Changes to configuration inputs during a frame SHALL produce undefined results for that frame only; the next IDLE SHALL use the new values.

Reset
REQ-034 While reset is high: state = IDLE, counters = 0, synchroniser flops = 1, rx_data = 0, rx_valid = 0, all error flags = 0, overrun = 0.
REQ-035 Reset mid-frame SHALL abort the frame with no output; reception resumes on the first falling edge after reset is released.

Structure
REQ-036 Package uart_pkg SHALL hold the baud divisor function and table, the parity_mode encoding and the FSM state enum.
REQ-037 Sub-module uart_baud_tick SHALL generate the oversample tick from baud_sel and a restart input.
REQ-038 An implementation SHALL be 120-400 RTL lines.

Verification
REQ-039 8N1 at 115200, byte 0xA5, rx_ready held 1 -> rx_valid for 1 cycle, rx_data 0xA5, all flags 0.
REQ-040 7E2 at 9600, byte 0x35 with parity bit forced 1 -> rx_data 0x35, parity_err 1, frame_err 0.
REQ-041 A 0.3-bit low glitch on an idle line -> no rx_valid, state back to IDLE.
REQ-042 Two 8N1 frames 0x11 then 0x22 with rx_ready 0 -> rx_data 0x11 held, overrun pulses once, then assert rx_ready -> 0x11 accepted, 0x22 lost.
REQ-043 Line held low for 2 frame times -> one byte 0x00 with break_det 1 and frame_err 1; no second byte until the line returns high.
REQ-044 Reset asserted at data bit 4, then 8N1 frame 0x5A -> no output from the aborted frame, then 0x5A with clean flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: baud divisor table, parity encoding, FSM states.
package uart_pkg;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} rx_state_e;

  localparam logic [1:0] ParNone  = 2'd0;
  localparam logic [1:0] ParEven  = 2'd1;
  localparam logic [1:0] ParOdd   = 2'd2;
  localparam logic [1:0] ParNone3 = 2'd3;

  localparam int unsigned BaudTable [8] = '{9600, 19200, 38400, 57600,
                                            115200, 230400, 460800, 921600};

  // Clocks per oversample tick; clamped to 1 so a slow clock still produces ticks.
  function automatic int unsigned baud_div(int unsigned clk_freq, int unsigned os,
                                           logic [2:0] sel);
    int unsigned d;
    d = clk_freq / (BaudTable[sel] * os);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one pulse every DIV clocks, restartable.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_sel,
  input  logic       restart,
  output logic       tick
);

  localparam int unsigned MaxDiv = baud_div(CLK_FREQ, OVERSAMPLE, 3'd0);
  localparam int unsigned CntW   = $clog2(MaxDiv + 1);

  logic [CntW-1:0] w_div_m1 [8];
  logic [CntW-1:0] w_last;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_baud;
  logic            w_restart;
  logic            w_wrap;

  for (genvar g = 0; g < 8; g++) begin : g_div
    assign w_div_m1[g] = CntW'(baud_div(CLK_FREQ, OVERSAMPLE, 3'(g)) - 1);
  end

  assign w_last    = w_div_m1[baud_sel];
  assign w_restart = restart | (baud_sel != r_baud);
  assign w_wrap    = (r_cnt == w_last);
  assign tick      = w_wrap & ~w_restart;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_baud <= '0;
    end else begin
      r_baud <= baud_sel;
      if (w_restart || w_wrap) r_cnt <= '0;
      else                     r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with runtime-selectable baud, framing and parity.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_sel,
  input  logic [1:0] data_bits,
  input  logic [1:0] parity_mode,
  input  logic       stop2,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       overrun
);

  localparam int unsigned OsW = $clog2(OVERSAMPLE);
  localparam logic [OsW-1:0] IdxLo   = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [OsW-1:0] IdxMid  = OsW'(OVERSAMPLE / 2);
  localparam logic [OsW-1:0] IdxHi   = OsW'(OVERSAMPLE / 2 + 1);
  localparam logic [OsW-1:0] IdxLast = OsW'(OVERSAMPLE - 1);

  rx_state_e r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxd_prev;
  logic [OsW-1:0]         r_os_cnt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic [1:0]             r_samp;
  logic                   r_par, r_zero, r_perr, r_ferr, r_brk, r_brk_blk;
  logic [7:0]             r_data;
  logic                   r_valid, r_perr_o, r_ferr_o, r_brk_o, r_overrun;

  logic w_rxd, w_tick, w_restart, w_edge, w_vote, w_vote_tick, w_end_tick;
  logic w_last_data, w_par_en, w_last_stop, w_done;
  logic w_ferr_fin, w_brk_fin, w_load;
  logic [7:0] w_data;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .baud_sel(baud_sel),
    .restart (w_restart),
    .tick    (w_tick)
  );

  assign w_rxd       = r_sync[SYNC_STAGES-1];
  assign w_restart   = (r_state == StIdle);
  assign w_edge      = r_rxd_prev & ~w_rxd & ~r_brk_blk;
  assign w_vote      = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rxd) | (r_samp[1] & w_rxd);
  assign w_vote_tick = w_tick && (r_os_cnt == IdxHi);
  assign w_end_tick  = w_tick && (r_os_cnt == IdxLast);
  assign w_last_data = (r_bit_cnt == ({1'b0, data_bits} + 3'd4));
  assign w_par_en    = (parity_mode == ParEven) || (parity_mode == ParOdd);
  assign w_last_stop = !stop2 || (r_bit_cnt == 3'd1);
  // Only meaningful on a stop-bit vote tick.
  assign w_ferr_fin  = r_ferr | ~w_vote;
  assign w_brk_fin   = r_brk | ((r_bit_cnt == 3'd0) & r_zero & ~w_vote);
  // Data was shifted in from the MSB end; realign so unused upper bits read as 0.
  assign w_data      = r_shift >> (2'd3 - data_bits);

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle:   if (w_edge) w_state_next = StStart;
      StStart: begin
        if (w_vote_tick && w_vote) w_state_next = StIdle;
        else if (w_end_tick)       w_state_next = StData;
      end
      StData:   if (w_end_tick && w_last_data) w_state_next = w_par_en ? StParity : StStop;
      StParity: if (w_end_tick) w_state_next = StStop;
      StStop: begin
        if (w_vote_tick && w_last_stop) begin
          w_state_next = StIdle;
          w_done       = 1'b1;
        end
      end
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync     <= '1;
      r_rxd_prev <= 1'b1;
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_samp     <= '0;
      r_par      <= 1'b0;
      r_zero     <= 1'b1;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
      r_brk_blk  <= 1'b0;
    end else begin
      r_sync[0] <= rxd;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_rxd_prev <= w_rxd;
      if (r_state == StIdle) begin
        r_os_cnt  <= '0;
        r_bit_cnt <= '0;
        r_shift   <= '0;
        r_par     <= 1'b0;
        r_zero    <= 1'b1;
        r_perr    <= 1'b0;
        r_ferr    <= 1'b0;
        r_brk     <= 1'b0;
        if (w_rxd) r_brk_blk <= 1'b0;
      end else if (w_tick) begin
        r_os_cnt <= (r_os_cnt == IdxLast) ? '0 : r_os_cnt + 1'b1;
        if (r_os_cnt == IdxLo)  r_samp[0] <= w_rxd;
        if (r_os_cnt == IdxMid) r_samp[1] <= w_rxd;
        if (r_os_cnt == IdxHi) begin
          if (r_state == StData) begin
            r_shift <= {w_vote, r_shift[7:1]};
            r_par   <= r_par ^ w_vote;
            r_zero  <= r_zero & ~w_vote;
          end
          if (r_state == StParity) begin
            r_perr <= r_par ^ w_vote ^ (parity_mode == ParOdd);
            r_zero <= r_zero & ~w_vote;
          end
          if (r_state == StStop) begin
            r_ferr <= w_ferr_fin;
            r_brk  <= w_brk_fin;
          end
        end
        if (r_os_cnt == IdxLast) begin
          if (r_state == StData) r_bit_cnt <= w_last_data ? 3'd0 : r_bit_cnt + 3'd1;
          if (r_state == StStop) r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_done) r_brk_blk <= w_brk_fin;
      end
    end
  end

  // A pending byte survives a new completion unless it is being accepted this cycle.
  assign w_load = w_done & (~r_valid | rx_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr_o  <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_brk_o   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_done & r_valid & ~rx_ready;
      if (w_load) begin
        r_data   <= w_data;
        r_valid  <= 1'b1;
        r_perr_o <= r_perr;
        r_ferr_o <= w_ferr_fin;
        r_brk_o  <= w_brk_fin;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr_o;
  assign frame_err  = r_ferr_o;
  assign break_det  = r_brk_o;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised scoreboard bench for uart_rx_param with directed corner frames.
module tb_uart_rx_param;

  localparam int ClkFreq = 16_000_000;
  localparam int Os      = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_sel;
  logic [1:0] data_bits;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err, frame_err, break_det, overrun;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ   (ClkFreq),
    .OVERSAMPLE (Os),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_sel   (baud_sel),
    .data_bits  (data_bits),
    .parity_mode(parity_mode),
    .stop2      (stop2),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .overrun    (overrun)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bk;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_rx = 0;
  int   ovr_seen = 0;
  int   valid_cycles = 0;
  int   rdy_mode = 0;
  logic rdy_man = 1'b0;
  int   bauds [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};

  function automatic int bit_clks(int sel);
    int d;
    d = ClkFreq / (bauds[sel] * Os);
    if (d < 1) d = 1;
    return d * Os;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Consumer: manual level or random acceptance.
  initial begin
    rx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0) rx_ready = rdy_man;
      else               rx_ready = rx_valid && ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: pops the scoreboard on every accepted byte and checks hold stability.
  logic        prev_hold = 1'b0;
  logic [10:0] prev_bus;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (overrun) ovr_seen++;
      if (rx_valid) valid_cycles++;
      if (prev_hold)
        chk("hold_stable", {rx_valid, rx_data, parity_err, frame_err, break_det},
            {1'b1, prev_bus});
      if (rx_valid && rx_ready) begin
        n_rx++;
        chk("output_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rx_data", rx_data, e.data);
          chk("rx_flags_pe_fe_bk", {parity_err, frame_err, break_det}, {e.pe, e.fe, e.bk});
        end
      end
      prev_hold = rx_valid && !rx_ready;
      prev_bus  = {rx_data, parity_err, frame_err, break_det};
    end
  end

  task automatic send_frame(input int sel, input logic [7:0] d, input int nb, input int pm,
                            input bit s2, input bit pflip, input bit sbad, input bit expect_out);
    logic [7:0] dm;
    logic       par;
    logic       has_par;
    int         bc;
    rsp_t       r;
    logic       bits[$];
    baud_sel    = 3'(sel);
    data_bits   = 2'(nb - 5);
    parity_mode = 2'(pm);
    stop2       = s2;
    bc          = bit_clks(sel);
    dm          = d & 8'((1 << nb) - 1);
    has_par     = (pm == 1) || (pm == 2);
    par         = (^dm) ^ (pm == 2) ^ pflip;
    if (expect_out) begin
      r.data = dm;
      r.pe   = has_par ? ((^dm) ^ par ^ (pm == 2)) : 1'b0;
      r.fe   = sbad;
      r.bk   = (dm == 8'd0) && (!has_par || !par) && sbad;
      exp_q.push_back(r);
    end
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
    if (has_par) bits.push_back(par);
    bits.push_back(!sbad);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) begin
      rxd = bits[i];
      cyc(bc);
    end
    rxd = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    chk("drain_in_time", exp_q.size(), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, rx0, ovr0, v0;
    reset = 1'b1; rxd = 1'b1; baud_sel = 3'd4; data_bits = 2'd3;
    parity_mode = 2'd0; stop2 = 1'b0;
    cyc(4);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_flags", {parity_err, frame_err, break_det}, 0);
    chk("reset_overrun", overrun, 0);
    reset = 1'b0;
    cyc(8);
    bc = bit_clks(4);

    // 8N1 0xA5 at 115200 with ready held high: single-cycle valid.
    rdy_mode = 0; rdy_man = 1'b1;
    v0 = valid_cycles;
    send_frame(4, 8'hA5, 8, 0, 0, 0, 0, 1);
    wait_drain(4000);
    cyc(bc);
    chk("a5_valid_width", valid_cycles - v0, 1);

    // 7E2 at 9600, 0x35 with parity bit forced to 1.
    send_frame(0, 8'h35, 7, 1, 1, 1, 0, 1);
    wait_drain(4000);

    // 0.3-bit glitch is a false start.
    rdy_mode = 1;
    baud_sel = 3'd4;
    cyc(bc);
    rx0 = n_rx;
    rxd = 1'b0;
    cyc(bc * 3 / 10);
    rxd = 1'b1;
    cyc(20 * bc);
    chk("glitch_no_output", n_rx - rx0, 0);
    chk("glitch_valid_low", rx_valid, 0);
    send_frame(4, 8'hC3, 8, 0, 0, 0, 0, 1);
    wait_drain(4000);

    // Overrun: second frame dropped while first byte pending.
    rdy_mode = 0; rdy_man = 1'b0;
    cyc(bc);
    rx0 = n_rx; ovr0 = ovr_seen;
    send_frame(4, 8'h11, 8, 0, 0, 0, 0, 1);
    send_frame(4, 8'h22, 8, 0, 0, 0, 0, 0);
    cyc(2 * bc);
    chk("overrun_pulses", ovr_seen - ovr0, 1);
    chk("held_valid", rx_valid, 1);
    chk("held_data", rx_data, 8'h11);
    rdy_man = 1'b1;
    cyc(1);
    rdy_man = 1'b0;
    cyc(bc);
    chk("overrun_accepts", n_rx - rx0, 1);
    chk("after_accept_valid", rx_valid, 0);

    // Break: line low for two frame times.
    rdy_mode = 1;
    rx0 = n_rx;
    baud_sel = 3'd4; data_bits = 2'd3; parity_mode = 2'd0; stop2 = 1'b0;
    exp_q.push_back('{data: 8'h00, pe: 1'b0, fe: 1'b1, bk: 1'b1});
    rxd = 1'b0;
    cyc(20 * bc);
    chk("break_one_byte", n_rx - rx0, 1);
    rxd = 1'b1;
    cyc(bc);
    send_frame(4, 8'h3C, 8, 0, 0, 0, 0, 1);
    wait_drain(4000);
    chk("break_then_frame", n_rx - rx0, 2);

    // Reset during data bit 4 aborts the frame.
    rx0 = n_rx;
    rxd = 1'b0;
    cyc(bc);
    for (int i = 0; i < 4; i++) begin
      rxd = (8'h5A >> i) & 8'h01;
      cyc(bc);
    end
    rxd = 1'b1;
    cyc(bc / 2);
    reset = 1'b1;
    cyc(3);
    chk("abort_reset_valid", rx_valid, 0);
    reset = 1'b0;
    cyc(2 * bc);
    chk("abort_no_output", n_rx - rx0, 0);
    send_frame(4, 8'h5A, 8, 0, 0, 0, 0, 1);
    wait_drain(4000);

    // Random frames at the faster rates, random gaps including zero.
    for (int k = 0; k < 20; k++) begin
      int   sel, nb, pm, gap;
      bit   s2, pflip, sbad;
      logic [7:0] d;
      sel   = $urandom_range(4, 7);
      nb    = $urandom_range(5, 8);
      pm    = $urandom_range(0, 3);
      s2    = 1'($urandom_range(0, 1));
      d     = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      pflip = ($urandom_range(0, 3) == 0);
      sbad  = ($urandom_range(0, 7) == 0);
      send_frame(sel, d, nb, pm, s2, pflip, sbad, 1);
      gap = $urandom_range(0, 2);
      if (sbad && !s2) gap++;
      cyc(gap * bit_clks(sel));
    end
    wait_drain(4000);
    cyc(2 * bc);

    chk("final_queue_empty", exp_q.size(), 0);
    chk("overrun_total", ovr_seen, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
